// File: rtl/lsu_bridge.sv
// Load/store bridge between a single-cycle core datapath and a valid/ready style data-memory bus.
// Legal accesses walk IDLE->REQ->RESP->DONE, stalling the core until the response is in.
module lsu_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AccessErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    // Bus handshake: mem_req rises in REQ and holds with stable addr/we/be/wdata until
    // the cycle mem_gnt is seen; mem_rvalid is then accepted once in RESP (data or write ack).
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [2:0]     f3_q;
    logic [1:0]     off_q;
    logic           we_q;
    logic [3:0]     be_q;
    logic [31:0]    addr_q, wdata_q;

    logic           access, illegal, bad_f3, misalign, start, timeout, abort;
    logic [3:0]     be_new;
    logic [31:0]    wdata_new, lane, load_data;

    assign access   = MemRead ^ MemWrite;
    assign bad_f3   = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11) || (MemWrite && Funct3[2]);
    assign misalign = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                      ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
    assign illegal  = (MemRead && MemWrite) || (access && (bad_f3 || misalign));
    assign start    = (state == IDLE) && access && !illegal;
    // >= rather than == so a grant landing on the last allowed cycle still times out in RESP
    assign timeout  = (cnt >= CW'(TIMEOUT_CYCLES - 1));
    assign abort    = timeout && (((state == REQ) && !mem_gnt) || ((state == RESP) && !mem_rvalid));

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = WriteData;
        case (Funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << ALUResult[1:0];
                wdata_new = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << ALUResult[1:0];
                wdata_new = {2{WriteData[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data = lane;
        case (f3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'd0, lane[7:0]};
            3'b101:  load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        AccessErr = 1'b0;
        case (state)
            IDLE: begin
                AccessErr = illegal;
                if (start) begin
                    Stall     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (mem_gnt)      state_nxt = RESP;
                else if (timeout) state_nxt = DONE;
            end
            RESP: begin
                Stall = 1'b1;
                if (mem_rvalid || timeout) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            ReadData <= 32'd0;
            BusErr   <= 1'b0;
        end else begin
            state  <= state_nxt;
            BusErr <= abort;
            if (start) begin
                cnt     <= '0;
                f3_q    <= Funct3;
                off_q   <= ALUResult[1:0];
                we_q    <= MemWrite;
                be_q    <= be_new;
                addr_q  <= {ALUResult[31:2], 2'b00};
                wdata_q <= wdata_new;
            end else if ((state == REQ) || (state == RESP)) begin
                cnt <= cnt + CW'(1);
            end
            if ((state == RESP) && mem_rvalid && !we_q) ReadData <= load_data;
            if (abort && !we_q) ReadData <= 32'd0;
        end
    end

    assign mem_req   = (state == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state;
endmodule

// File: tb/tb_lsu_bridge.sv
// Directed bench for lsu_bridge: loads/stores with hand-computed bus fields and results,
// illegal-access table, bus timeout and reset in the middle of an access.
module tb_lsu_bridge;
    logic        clk, reset, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData, ReadData, mem_addr, mem_wdata, mem_rdata;
    logic        Stall, AccessErr, BusErr, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    lsu_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .AccessErr(AccessErr), .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full legal access; entered and left at posedge+1 with the DUT in IDLE.
    task automatic mem_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input int gnt_delay,
                              input logic [31:0] rdata, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rd, input string tag);
        int stalls;
        stalls     = 0;
        MemRead    = rd;
        MemWrite   = wr;
        Funct3     = f3;
        ALUResult  = addr;
        WriteData  = wd;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check({tag, ".idle_err"}, 32'(AccessErr), 32'd0);
        check({tag, ".idle_req"}, 32'(mem_req), 32'd0);
        if (Stall) stalls++;
        step();
        for (int i = 0; i <= gnt_delay; i++) begin
            mem_gnt = (i == gnt_delay);
            @(negedge clk);
            check({tag, ".req"},   32'(mem_req), 32'd1);
            check({tag, ".addr"},  mem_addr, exp_addr);
            check({tag, ".be"},    32'(mem_be), 32'(exp_be));
            check({tag, ".wdata"}, mem_wdata, exp_wdata);
            check({tag, ".we"},    32'(mem_we), 32'(wr));
            if (Stall) stalls++;
            step();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        check({tag, ".resp_req"}, 32'(mem_req), 32'd0);
        if (Stall) stalls++;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        @(negedge clk);
        check({tag, ".done_stall"}, 32'(Stall), 32'd0);
        check({tag, ".rdata"},      ReadData, exp_rd);
        check({tag, ".buserr"},     32'(BusErr), 32'd0);
        check({tag, ".state"},      32'(dbg_state), 32'd3);
        check({tag, ".stalls"},     32'(stalls), 32'(3 + gnt_delay));
        step();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    logic        ill_rd[8], ill_wr[8];
    logic [2:0]  ill_f3[8];
    logic [31:0] ill_addr[8];

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        ALUResult = 32'd0; WriteData = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

        ill_rd   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ill_wr   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ill_f3   = '{3'b010, 3'b010, 3'b011, 3'b110, 3'b100, 3'b001, 3'b101, 3'b010};
        ill_addr = '{32'h101, 32'h100, 32'h100, 32'h100, 32'h100, 32'h103, 32'h101, 32'h102};

        // reset state
        repeat (2) @(negedge clk);
        check("rst.rdata", ReadData, 32'd0);
        check("rst.req",   32'(mem_req), 32'd0);
        check("rst.stall", 32'(Stall), 32'd0);
        check("rst.buserr", 32'(BusErr), 32'd0);
        check("rst.state", 32'(dbg_state), 32'd0);
        check("rst.addr",  mem_addr, 32'd0);
        step();
        reset = 1'b1;
        step();

        // loads
        mem_access(1, 0, 3'b010, 32'h100, 32'd0, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'd0, 32'hDEADBEEF, "lw");
        mem_access(1, 0, 3'b000, 32'h103, 32'd0, 0, 32'h80112233, 32'h100, 4'b1000, 32'd0, 32'hFFFFFF80, "lb");
        mem_access(1, 0, 3'b100, 32'h103, 32'd0, 0, 32'h80112233, 32'h100, 4'b1000, 32'd0, 32'h00000080, "lbu");
        mem_access(1, 0, 3'b001, 32'h102, 32'd0, 1, 32'h80112233, 32'h100, 4'b1100, 32'd0, 32'hFFFF8011, "lh");
        mem_access(1, 0, 3'b101, 32'h102, 32'd0, 0, 32'h7FFF0000, 32'h100, 4'b1100, 32'd0, 32'h00007FFF, "lhu");
        mem_access(1, 0, 3'b000, 32'h001, 32'd0, 0, 32'h00007F00, 32'h000, 4'b0010, 32'd0, 32'h0000007F, "lb1");

        // stores leave ReadData at 0x7F
        mem_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 3, 32'hFFFFFFFF, 32'h200, 4'b1100, 32'hABCDABCD, 32'h7F, "sh");
        mem_access(0, 1, 3'b000, 32'h301, 32'h12345678, 1, 32'hFFFFFFFF, 32'h300, 4'b0010, 32'h78787878, 32'h7F, "sb");
        mem_access(0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 0, 32'hFFFFFFFF, 32'h400, 4'b1111, 32'hCAFEF00D, 32'h7F, "sw");

        // illegal accesses
        for (int i = 0; i < 8; i++) begin
            MemRead = ill_rd[i]; MemWrite = ill_wr[i]; Funct3 = ill_f3[i]; ALUResult = ill_addr[i];
            @(negedge clk);
            check($sformatf("ill%0d.err", i),   32'(AccessErr), 32'd1);
            check($sformatf("ill%0d.stall", i), 32'(Stall), 32'd0);
            step();
            @(negedge clk);
            check($sformatf("ill%0d.req", i),   32'(mem_req), 32'd0);
            check($sformatf("ill%0d.state", i), 32'(dbg_state), 32'd0);
            check($sformatf("ill%0d.rdata", i), ReadData, 32'h7F);
            step();
        end
        MemRead = 1'b0; MemWrite = 1'b0;

        // timeout: grant at once, rvalid never
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h500;
        step();
        mem_gnt = 1'b1;
        @(negedge clk);
        check("to.req", 32'(mem_req), 32'd1);
        step();
        mem_gnt = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check($sformatf("to.resp%0d.stall", i), 32'(Stall), 32'd1);
            check($sformatf("to.resp%0d.buserr", i), 32'(BusErr), 32'd0);
            step();
        end
        @(negedge clk);
        check("to.buserr", 32'(BusErr), 32'd1);
        check("to.rdata",  ReadData, 32'd0);
        check("to.stall",  32'(Stall), 32'd0);
        check("to.state",  32'(dbg_state), 32'd3);
        step();
        MemRead = 1'b0;
        @(negedge clk);
        check("to.pulse_end", 32'(BusErr), 32'd0);
        step();
        mem_access(1, 0, 3'b010, 32'h104, 32'd0, 0, 32'h11223344, 32'h104, 4'b1111, 32'd0, 32'h11223344, "after_to");

        // reset while in RESP
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h600;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        @(negedge clk);
        check("rr.in_resp", 32'(dbg_state), 32'd2);
        #2;
        reset = 1'b0;
        MemRead = 1'b0;
        #1;
        check("rr.req",   32'(mem_req), 32'd0);
        check("rr.state", 32'(dbg_state), 32'd0);
        check("rr.rdata", ReadData, 32'd0);
        step();
        reset = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("rr.late_rdata", ReadData, 32'd0);
        check("rr.late_state", 32'(dbg_state), 32'd0);
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("rr.after_rdata", ReadData, 32'd0);
        check("rr.after_req",   32'(mem_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
